latch_event_reporter: RTL and testbench

- Receive-side companion to the sticky high latch: accumulates pulsed status bits, then drains them one at a time as indexed events over a valid/ready stream.
- Each reported bit is cleared automatically. Software or a downstream FSM consumes individual events instead of polling and clearing a whole vector.
- Sits between status/fault pulse sources and an AXI-Stream FIFO or interrupt/event logger.

---
 rtl/latch_event_reporter.sv | 122 ++++++++++++
 tb/tb_latch_event_reporter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_event_reporter.sv
// Latches pulsed status bits and drains them one at a time as indexed events
// over a valid/ready stream. Define LATCH_EVENT_REPORTER_TIMESTAMP_EN to add out_timestamp.
module latch_event_reporter #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] overflow,
    input  logic             clear_overflow
`ifdef LATCH_EVENT_REPORTER_TIMESTAMP_EN
    ,
    output logic [31:0]      out_timestamp
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] rr;
    logic [IDX_W-1:0] rr_next;
    logic [IDX_W-1:0] out_index_next;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             load;
    logic             grant;
    logic [WIDTH-1:0] grant_mask;
    logic [WIDTH-1:0] pending_next;
    logic [WIDTH-1:0] overflow_next;

    // Round-robin search: first set bit of vec at or after start, wrapping to 0.
    // Result is {found, index}.
    function automatic logic [IDX_W:0] find_from(input logic [WIDTH-1:0] vec,
                                                 input logic [IDX_W-1:0] start);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            j = int'(start) + i;
            if (j >= WIDTH) begin
                j = j - WIDTH;
            end
            if (!res[IDX_W] && vec[IDX_W'(j)]) begin
                res = {1'b1, IDX_W'(j)};
            end
        end
        return res;
    endfunction

    assign out_valid = (state == PRESENT);

    always_comb begin
        {sel_found, sel_idx} = find_from(pending, rr);
        load           = (state == IDLE) || out_ready;
        grant          = load && sel_found;
        grant_mask     = '0;
        state_next     = state;
        rr_next        = rr;
        out_index_next = out_index;

        if (grant) begin
            grant_mask[sel_idx] = 1'b1;
        end

        // A pulse landing on the granted bit re-arms it rather than being lost.
        pending_next  = (pending & ~grant_mask) | din;
        overflow_next = clear_overflow ? '0 : (overflow | (din & pending & ~grant_mask));

        if (load) begin
            if (sel_found) begin
                state_next     = PRESENT;
                out_index_next = sel_idx;
                rr_next        = (sel_idx == IDX_W'(WIDTH - 1)) ? '0 : sel_idx + IDX_W'(1);
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr        <= '0;
            out_index <= '0;
            pending   <= '0;
            overflow  <= '0;
        end else begin
            state     <= state_next;
            rr        <= rr_next;
            out_index <= out_index_next;
            pending   <= pending_next;
            overflow  <= overflow_next;
        end
    end

`ifdef LATCH_EVENT_REPORTER_TIMESTAMP_EN
    logic [31:0] ts_count;

    // Free-running counter; its value on the grant cycle travels with the event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_count      <= '0;
            out_timestamp <= '0;
        end else begin
            ts_count <= ts_count + 32'd1;
            if (grant) begin
                out_timestamp <= ts_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_latch_event_reporter.sv
// Self-checking bench for latch_event_reporter (WIDTH=8) using an expected-index
// queue that is popped on every accepted handshake.
module tb_latch_event_reporter;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             out_ready = 1'b0;
    logic             clear_overflow = 1'b0;
    logic             out_valid;
    logic [IDX_W-1:0] out_index;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] overflow;
`ifdef LATCH_EVENT_REPORTER_TIMESTAMP_EN
    logic [31:0]      out_timestamp;
`endif

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int exp_idx;

    always #5 clk = ~clk;

    latch_event_reporter #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .din           (din),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .pending       (pending),
        .overflow      (overflow),
        .clear_overflow(clear_overflow)
`ifdef LATCH_EVENT_REPORTER_TIMESTAMP_EN
        ,
        .out_timestamp (out_timestamp)
`endif
    );

    // Scoreboard: every accepted event must match the oldest expected index.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard_extra: got index %0d, expected no event", out_index);
            end else begin
                exp_idx = exp_q.pop_front();
                if (out_index !== IDX_W'(exp_idx)) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_index: got %0d expected %0d", out_index, exp_idx);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        din   = '0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_index !== 3'd0) begin errors++; $display("[TB] FAIL reset_index: got %0d expected 0", out_index); end
        checks++; if (pending !== 8'h00) begin errors++; $display("[TB] FAIL reset_pending: got %h expected 00", pending); end
        checks++; if (overflow !== 8'h00) begin errors++; $display("[TB] FAIL reset_overflow: got %h expected 00", overflow); end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_bit();
        out_ready = 1'b1;
        din = 8'h04;
        exp_q.push_back(2);
        tick();
        din = '0;
        checks++; if (pending !== 8'h04 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_n1: got pending=%h valid=%b expected 04/0", pending, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 3'd2) begin errors++; $display("[TB] FAIL single_n2: got valid=%b index=%0d expected 1/2", out_valid, out_index); end
        checks++; if (pending !== 8'h00) begin errors++; $display("[TB] FAIL single_n2_pending: got %h expected 00", pending); end
        tick();
        checks++; if (out_valid !== 1'b0 || pending !== 8'h00) begin errors++; $display("[TB] FAIL single_n3: got valid=%b pending=%h expected 0/00", out_valid, pending); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL single_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_round_robin_stall();
        pulse_reset();
        out_ready = 1'b0;
        din = 8'h81;
        exp_q.push_back(0);
        exp_q.push_back(7);
        tick();
        din = '0;
        checks++; if (pending !== 8'h81) begin errors++; $display("[TB] FAIL rr_pending: got %h expected 81", pending); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 3'd0 || pending !== 8'h80) begin errors++; $display("[TB] FAIL rr_first: got valid=%b index=%0d pending=%h expected 1/0/80", out_valid, out_index, pending); end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_index !== 3'd0 || pending !== 8'h80) begin errors++; $display("[TB] FAIL rr_stall%0d: got valid=%b index=%0d pending=%h expected 1/0/80", c, out_valid, out_index, pending); end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 3'd7 || pending !== 8'h00) begin errors++; $display("[TB] FAIL rr_second: got valid=%b index=%0d pending=%h expected 1/7/00", out_valid, out_index, pending); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle: got valid=%b expected 0", out_valid); end
    endtask

    task automatic test_wrap_around();
        out_ready = 1'b1;
        din = 8'h40;
        exp_q.push_back(6);
        tick();
        din = '0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL wrap_six: got valid=%b left=%0d expected 0/0", out_valid, exp_q.size()); end
        din = 8'h03;
        exp_q.push_back(0);
        exp_q.push_back(1);
        tick();
        din = '0;
        tick();
        checks++; if (out_index !== 3'd0) begin errors++; $display("[TB] FAIL wrap_first: got %0d expected 0", out_index); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 3'd1) begin errors++; $display("[TB] FAIL wrap_second: got valid=%b index=%0d expected 1/1", out_valid, out_index); end
        tick();
        din = 8'h80;
        exp_q.push_back(7);
        tick();
        din = '0;
        tick();
        tick();
        din = 8'hC1;
        exp_q.push_back(0);
        exp_q.push_back(6);
        exp_q.push_back(7);
        tick();
        din = '0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 3'd0) begin errors++; $display("[TB] FAIL b2b_0: got valid=%b index=%0d expected 1/0", out_valid, out_index); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 3'd6) begin errors++; $display("[TB] FAIL b2b_6: got valid=%b index=%0d expected 1/6", out_valid, out_index); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 3'd7) begin errors++; $display("[TB] FAIL b2b_7: got valid=%b index=%0d expected 1/7", out_valid, out_index); end
        tick();
        checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_end: got valid=%b left=%0d expected 0/0", out_valid, exp_q.size()); end
    endtask

    task automatic test_overflow();
        bit done;
        out_ready = 1'b0;
        din = 8'h01;
        exp_q.push_back(0);
        tick();
        din = '0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 3'd0) begin errors++; $display("[TB] FAIL ovf_held: got valid=%b index=%0d expected 1/0", out_valid, out_index); end
        din = 8'h10;
        tick();
        din = '0;
        tick();
        checks++; if (pending !== 8'h10 || overflow !== 8'h00) begin errors++; $display("[TB] FAIL ovf_first: got pending=%h overflow=%h expected 10/00", pending, overflow); end
        din = 8'h10;
        tick();
        din = '0;
        checks++; if (overflow !== 8'h10) begin errors++; $display("[TB] FAIL ovf_set: got %h expected 10", overflow); end
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        checks++; if (overflow !== 8'h00) begin errors++; $display("[TB] FAIL ovf_clear: got %h expected 00", overflow); end
        din = 8'h10;
        clear_overflow = 1'b1;
        tick();
        din = '0;
        clear_overflow = 1'b0;
        checks++; if (overflow !== 8'h00 || pending !== 8'h10) begin errors++; $display("[TB] FAIL ovf_clear_wins: got overflow=%h pending=%h expected 00/10", overflow, pending); end
        tick();
        checks++; if (overflow !== 8'h00) begin errors++; $display("[TB] FAIL ovf_stays_clear: got %h expected 00", overflow); end
        exp_q.push_back(4);
        out_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (exp_q.size() == 0 && out_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        checks++; if (!done) begin errors++; $display("[TB] FAIL ovf_drain: got %0d events left expected 0", exp_q.size()); end
    endtask

    task automatic test_collision();
        out_ready = 1'b1;
        din = 8'h08;
        exp_q.push_back(3);
        exp_q.push_back(3);
        tick();
        tick();
        din = '0;
        checks++; if (out_valid !== 1'b1 || out_index !== 3'd3 || pending !== 8'h08) begin errors++; $display("[TB] FAIL coll_grant: got valid=%b index=%0d pending=%h expected 1/3/08", out_valid, out_index, pending); end
        checks++; if (overflow !== 8'h00) begin errors++; $display("[TB] FAIL coll_overflow: got %h expected 00", overflow); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 3'd3 || pending !== 8'h00) begin errors++; $display("[TB] FAIL coll_second: got valid=%b index=%0d pending=%h expected 1/3/00", out_valid, out_index, pending); end
        tick();
        checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL coll_end: got valid=%b left=%0d expected 0/0", out_valid, exp_q.size()); end
    endtask

    task automatic test_async_reset();
        bit done;
        out_ready = 1'b0;
        din = 8'h01;
        tick();
        din = '0;
        tick();
        din = 8'hF0;
        tick();
        din = '0;
        tick();
        din = 8'hF0;
        tick();
        din = '0;
        checks++; if (out_valid !== 1'b1 || pending !== 8'hF0 || overflow !== 8'hF0) begin errors++; $display("[TB] FAIL arst_setup: got valid=%b pending=%h overflow=%h expected 1/F0/F0", out_valid, pending, overflow); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid: got %b expected 0", out_valid); end
        checks++; if (pending !== 8'h00 || overflow !== 8'h00) begin errors++; $display("[TB] FAIL arst_state: got pending=%h overflow=%h expected 00/00", pending, overflow); end
        tick();
        reset = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        din = 8'h20;
        exp_q.push_back(5);
        tick();
        din = '0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 3'd5) begin errors++; $display("[TB] FAIL arst_after: got valid=%b index=%0d expected 1/5", out_valid, out_index); end
`ifdef LATCH_EVENT_REPORTER_TIMESTAMP_EN
        checks++; if (out_timestamp !== 32'd1) begin errors++; $display("[TB] FAIL arst_timestamp: got %0d expected 1", out_timestamp); end
`endif
        done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (exp_q.size() == 0 && out_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        checks++; if (!done) begin errors++; $display("[TB] FAIL arst_drain: got %0d events left expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_round_robin_stall();
        test_wrap_around();
        test_overflow();
        test_collision();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
